// File: rtl/muldiv_iter_pkg.sv
// Shared ALU op encoding, mul/div FSM states and op-class helpers.
package muldiv_iter_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_operation_type;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} muldiv_state_type;

  function automatic logic is_muldiv(input alu_operation_type op);
    return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_divop(input alu_operation_type op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// Combinational slice retiring STEP_BITS multiplier or quotient bits on unsigned magnitudes.
module muldiv_iter_step #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [2*XLEN-1:0] mc_in,
  input  logic [XLEN-1:0]   mp_in,
  output logic [2*XLEN-1:0] acc_out,
  output logic [2*XLEN-1:0] mc_out,
  output logic [XLEN-1:0]   mp_out
);

  // mul: acc += mc when mp[0], mc walks left, mp walks right.
  // div: acc is the partial remainder, mp shifts dividend out and quotient in, mc holds the divisor.
  logic [2*XLEN-1:0] a, m;
  logic [XLEN-1:0]   p;

  always_comb begin
    a = acc_in;
    m = mc_in;
    p = mp_in;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (is_div) begin
        a = {a[2*XLEN-2:0], p[XLEN-1]};
        p = {p[XLEN-2:0], 1'b0};
        if (a >= m) begin
          a    = a - m;
          p[0] = 1'b1;
        end
      end else begin
        if (p[0]) a = a + m;
        m = {m[2*XLEN-2:0], 1'b0};
        p = {1'b0, p[XLEN-1:1]};
      end
    end
    acc_out = a;
    mc_out  = m;
    mp_out  = p;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: magnitude datapath, one sign-fix cycle, valid/ready result.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_operation_type in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data
);

  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N + 1);

  if ((XLEN != 32 && XLEN != 64) || (XLEN % STEP_BITS) != 0) begin : g_param_check
    $error("muldiv_iter: XLEN must be 32/64 and divisible by STEP_BITS");
  end

  muldiv_state_type  state, state_nx;
  alu_operation_type op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q, mc_q, acc_nx, mc_nx;
  logic [XLEN-1:0]   mp_q, mp_nx;
  logic [CW-1:0]     cnt_q;

  logic              accept, sa, sb, neg_in, b_zero, ovf, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_data, fix_data, quo, rem_v;
  logic [2*XLEN-1:0] prod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    sa     = (in_op inside {MULH, MULHSU, DIV, REM}) && in_a[XLEN-1];
    sb     = (in_op inside {MULH, DIV, REM}) && in_b[XLEN-1];
    mag_a  = sa ? -in_a : in_a;
    mag_b  = sb ? -in_b : in_b;
    // MULHSU takes a's sign; a remainder takes the dividend's sign
    neg_in = (in_op inside {MULHSU, REM}) ? sa : (sa ^ sb);
    b_zero = (in_b == '0);
    ovf    = (in_op inside {DIV, REM}) && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
  end

  always_comb begin
    fast      = 1'b0;
    fast_data = '0;
    if (!is_muldiv(in_op)) begin
      fast = 1'b1;
    end else if (is_divop(in_op) && b_zero) begin
      fast      = 1'b1;
      fast_data = (in_op inside {DIV, DIVU}) ? '1 : in_a;
    end else if (ovf) begin
      fast      = 1'b1;
      fast_data = (in_op == DIV) ? in_a : '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = fast ? DONE : BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  muldiv_iter_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
    .is_div  (is_divop(op_q)),
    .acc_in  (acc_q),
    .mc_in   (mc_q),
    .mp_in   (mp_q),
    .acc_out (acc_nx),
    .mc_out  (mc_nx),
    .mp_out  (mp_nx)
  );

  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -mp_q : mp_q;
    rem_v    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fix_data = '0;
    case (op_q)
      MUL:                 fix_data = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_data = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_data = quo;
      REM, REMU:           fix_data = rem_v;
      default:             fix_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      cnt_q    <= '0;
      out_data <= '0;
    end else if (accept) begin
      op_q  <= in_op;
      neg_q <= neg_in;
      cnt_q <= CW'(N);
      acc_q <= '0;
      if (is_divop(in_op)) begin
        mc_q <= {{XLEN{1'b0}}, mag_b};
        mp_q <= mag_a;
      end else begin
        mc_q <= {{XLEN{1'b0}}, mag_a};
        mp_q <= mag_b;
      end
      if (fast) out_data <= fast_data;
    end else if (state == BUSY) begin
      acc_q <= acc_nx;
      mc_q  <= mc_nx;
      mp_q  <= mp_nx;
      cnt_q <= cnt_q - CW'(1);
    end else if (state == FIX && !flush) begin
      out_data <= fix_data;
    end
  end

  always @(posedge clk) begin
    if (!rst && accept) assert (is_muldiv(in_op)) else $error("muldiv_iter: non-M op %s accepted", in_op.name());
  end

endmodule
